rv_iopmp_tl_arbiter: RTL and testbench

Round-robin scheduler that shares one `rv_iopmp_transaction_logic` checker instance between `NUM_REQ` requesters, for example the AW and AR paths of the AXI data abstractor. It sits between the data abstractor(s) and the checker, which keeps `NUMBER_TL_INSTANCES` at 1 while adding request ports. It does four things:
- grants one request at a time;
- drives the checker's enable/operand handshake;
- bounds the wait for a verdict with a timeout;
- returns the allow/deny result to the granted requester only.

---
 rtl/rv_iopmp_pkg.sv | 23 ++
 rtl/rv_iopmp_rr_arbiter.sv | 40 ++++
 rtl/rv_iopmp_tl_arbiter.sv | 155 +++++++++++++++
 tb/tb_rv_iopmp_tl_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_iopmp_pkg.sv
// Shared types for the IOPMP blocks.
//   access_t       : transaction access type carried with each check request.
//   ACCESS_WIDTH   : bit width of access_t, for packing access types onto flat ports.
//   tl_arb_state_e : state encoding of the transaction-logic arbiter FSM.
package rv_iopmp_pkg;

  typedef enum logic [2:0] {
    ACCESS_NONE      = 3'b000,
    ACCESS_READ      = 3'b001,
    ACCESS_WRITE     = 3'b010,
    ACCESS_EXECUTION = 3'b100
  } access_t;

  localparam int unsigned ACCESS_WIDTH = $bits(access_t);

  typedef enum logic [1:0] {
    TL_ARB_IDLE,
    TL_ARB_ISSUE,
    TL_ARB_WAIT,
    TL_ARB_RESP
  } tl_arb_state_e;

endpackage

// File: rtl/rv_iopmp_rr_arbiter.sv
// Combinational round-robin pick.
// Searches valid_i starting at ptr_i, upward with wrap, and reports the first
// set bit found.
//   valid_i : per-requester request valid
//   ptr_i   : index with the highest priority this cycle
//   grant_o : one-hot grant (all zero when nothing is valid)
//   idx_o   : index of the granted requester (0 when nothing is valid)
//   any_o   : at least one requester is valid
module rv_iopmp_rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  int unsigned      j;
  logic [IDX_W-1:0] k;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    j       = 0;
    k       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      j = (32'(ptr_i) + i) % NUM_REQ;
      k = IDX_W'(j);
      if (!any_o && valid_i[k]) begin
        any_o      = 1'b1;
        grant_o[k] = 1'b1;
        idx_o      = k;
      end
    end
  end

endmodule

// File: rtl/rv_iopmp_tl_arbiter.sv
// Round-robin scheduler sharing one transaction-logic checker between
// NUM_REQ requesters. One request is in flight at a time:
// IDLE (grant) -> ISSUE (enable to checker) -> WAIT (verdict or timeout) -> RESP.
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset
//   req_valid_i/req_ready_o : per-requester request handshake (ready only in IDLE)
//   req_addr_i, req_num_bytes_i, req_sid_i, req_access_i : packed operands
//   rsp_valid_o/rsp_ready_i : per-requester verdict handshake (granted one only)
//   rsp_allow_o, rsp_timeout_o : verdict and "forced by timeout" flag, valid in RESP
//   chk_en_o, chk_addr_o, chk_num_bytes_o, chk_sid_o, chk_access_o : to checker
//   chk_ready_i, chk_valid_i, chk_allow_i : from checker
module rv_iopmp_tl_arbiter
  import rv_iopmp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned NB_WIDTH       = 4,
  parameter int unsigned SID_WIDTH      = 1,
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  output logic [NUM_REQ-1:0]               req_ready_o,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr_i,
  input  logic [NUM_REQ*NB_WIDTH-1:0]      req_num_bytes_i,
  input  logic [NUM_REQ*SID_WIDTH-1:0]     req_sid_i,
  input  logic [NUM_REQ*ACCESS_WIDTH-1:0]  req_access_i,
  output logic [NUM_REQ-1:0]               rsp_valid_o,
  input  logic [NUM_REQ-1:0]               rsp_ready_i,
  output logic                             rsp_allow_o,
  output logic                             rsp_timeout_o,
  output logic                             chk_en_o,
  output logic [ADDR_WIDTH-1:0]            chk_addr_o,
  output logic [NB_WIDTH-1:0]              chk_num_bytes_o,
  output logic [SID_WIDTH-1:0]             chk_sid_o,
  output logic [ACCESS_WIDTH-1:0]          chk_access_o,
  input  logic                             chk_ready_i,
  input  logic                             chk_valid_i,
  input  logic                             chk_allow_i
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  tl_arb_state_e state_q, state_d;

  logic [IDX_W-1:0]        rr_ptr_q;
  logic [NUM_REQ-1:0]      win_oh;
  logic [IDX_W-1:0]        win_idx;
  logic                    win_any;
  logic [NUM_REQ-1:0]      gnt_oh_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    at_limit;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [NB_WIDTH-1:0]     nb_q;
  logic [SID_WIDTH-1:0]    sid_q;
  logic [ACCESS_WIDTH-1:0] access_q;
  logic                    allow_q;
  logic                    timeout_q;

  rv_iopmp_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .valid_i (req_valid_i),
    .ptr_i   (rr_ptr_q),
    .grant_o (win_oh),
    .idx_o   (win_idx),
    .any_o   (win_any)
  );

  assign at_limit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      TL_ARB_IDLE:  if (win_any) state_d = TL_ARB_ISSUE;
      TL_ARB_ISSUE: if (chk_ready_i) state_d = TL_ARB_WAIT;
      TL_ARB_WAIT:  if (chk_valid_i || at_limit) state_d = TL_ARB_RESP;
      TL_ARB_RESP:  if (|(rsp_ready_i & gnt_oh_q)) state_d = TL_ARB_IDLE;
      default:      state_d = TL_ARB_IDLE;
    endcase
  end

  // Ready is masked while reset is held: the grant edge would be overridden
  // by reset, so advertising acceptance would drop the request silently.
  always_comb begin
    req_ready_o     = '0;
    rsp_valid_o     = '0;
    rsp_allow_o     = 1'b0;
    rsp_timeout_o   = 1'b0;
    chk_en_o        = 1'b0;
    chk_addr_o      = addr_q;
    chk_num_bytes_o = nb_q;
    chk_sid_o       = sid_q;
    chk_access_o    = access_q;
    case (state_q)
      TL_ARB_IDLE:  if (!rst_i) req_ready_o = win_oh;
      TL_ARB_ISSUE: chk_en_o = 1'b1;
      TL_ARB_RESP: begin
        rsp_valid_o   = gnt_oh_q;
        rsp_allow_o   = allow_q;
        rsp_timeout_o = timeout_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= TL_ARB_IDLE;
      rr_ptr_q  <= '0;
      gnt_oh_q  <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      nb_q      <= '0;
      sid_q     <= '0;
      access_q  <= '0;
      allow_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        TL_ARB_IDLE: begin
          if (win_any) begin
            gnt_oh_q <= win_oh;
            addr_q   <= req_addr_i[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
            nb_q     <= req_num_bytes_i[win_idx*NB_WIDTH +: NB_WIDTH];
            sid_q    <= req_sid_i[win_idx*SID_WIDTH +: SID_WIDTH];
            access_q <= req_access_i[win_idx*ACCESS_WIDTH +: ACCESS_WIDTH];
            rr_ptr_q <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
          end
        end
        TL_ARB_ISSUE: begin
          if (chk_ready_i) cnt_q <= '0;
        end
        TL_ARB_WAIT: begin
          // A real verdict takes priority over a timeout in the same cycle.
          if (chk_valid_i) begin
            allow_q   <= chk_allow_i;
            timeout_q <= 1'b0;
          end else if (at_limit) begin
            allow_q   <= 1'b0;
            timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_iopmp_tl_arbiter.sv
module tb_rv_iopmp_tl_arbiter;
  import rv_iopmp_pkg::*;

  localparam logic [63:0] A0 = 64'h0000_0000_8000_0000;
  localparam logic [63:0] A1 = 64'h0000_0001_2345_6780;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [127:0] req_addr;
  logic [7:0]   req_nb;
  logic [1:0]   req_sid;
  logic [5:0]   req_access;
  logic         rsp_allow, rsp_timeout;
  logic         chk_en, chk_ready, chk_valid, chk_allow;
  logic [63:0]  chk_addr;
  logic [3:0]   chk_nb;
  logic [0:0]   chk_sid;
  logic [2:0]   chk_access;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rv_iopmp_tl_arbiter #(
    .ADDR_WIDTH     (64),
    .NB_WIDTH       (4),
    .SID_WIDTH      (1),
    .NUM_REQ        (2),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_addr_i      (req_addr),
    .req_num_bytes_i (req_nb),
    .req_sid_i       (req_sid),
    .req_access_i    (req_access),
    .rsp_valid_o     (rsp_valid),
    .rsp_ready_i     (rsp_ready),
    .rsp_allow_o     (rsp_allow),
    .rsp_timeout_o   (rsp_timeout),
    .chk_en_o        (chk_en),
    .chk_addr_o      (chk_addr),
    .chk_num_bytes_o (chk_nb),
    .chk_sid_o       (chk_sid),
    .chk_access_o    (chk_access),
    .chk_ready_i     (chk_ready),
    .chk_valid_i     (chk_valid),
    .chk_allow_i     (chk_allow)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    step;
    step;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = 2'b11;
    step;
    step;
    vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
    vectors++; if (chk_en !== 1'b0) begin miscompares++; $display("FAIL reset_chk_en: got %b want 0", chk_en); end
    vectors++; if (rsp_valid !== 2'b00) begin miscompares++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
    vectors++; if ({rsp_allow, rsp_timeout} !== 2'b00) begin miscompares++; $display("FAIL reset_verdict: got %b want 00", {rsp_allow, rsp_timeout}); end
    vectors++; if ({chk_addr, chk_nb, chk_sid, chk_access} !== '0) begin miscompares++; $display("FAIL reset_operands: got %h want 0", {chk_addr, chk_nb, chk_sid, chk_access}); end
    rst = 1'b0;
    req_valid = 2'b00;
    chk_valid = 1'b1;
    chk_allow = 1'b1;
    step;
    chk_valid = 1'b0;
    chk_allow = 1'b0;
    step;
    vectors++; if ({rsp_valid, chk_en} !== 3'b000) begin miscompares++; $display("FAIL idle_chk_valid_ignored: got %b want 000", {rsp_valid, chk_en}); end
  endtask

  task automatic test_single;
    req_valid = 2'b01;
    chk_ready = 1'b1;
    #1;
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL single_grant: got %b want 01", req_ready); end
    step;
    req_valid = 2'b00;
    #1;
    vectors++; if (chk_en !== 1'b1) begin miscompares++; $display("FAIL single_issue_en: got %b want 1", chk_en); end
    vectors++; if (chk_addr !== A0) begin miscompares++; $display("FAIL single_addr: got %h want %h", chk_addr, A0); end
    vectors++; if ({chk_nb, chk_sid, chk_access} !== {4'd8, 1'b0, 3'b001}) begin miscompares++; $display("FAIL single_ops: got %h want %h", {chk_nb, chk_sid, chk_access}, {4'd8, 1'b0, 3'b001}); end
    vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL single_no_ready: got %b want 00", req_ready); end
    step;
    vectors++; if (chk_en !== 1'b0 || chk_addr !== A0) begin miscompares++; $display("FAIL single_wait: en=%b addr=%h want en=0 addr=%h", chk_en, chk_addr, A0); end
    chk_valid = 1'b1;
    chk_allow = 1'b1;
    step;
    chk_valid = 1'b0;
    chk_allow = 1'b0;
    vectors++; if (rsp_valid !== 2'b01) begin miscompares++; $display("FAIL single_rsp_valid: got %b want 01", rsp_valid); end
    vectors++; if ({rsp_allow, rsp_timeout} !== 2'b10) begin miscompares++; $display("FAIL single_verdict: got %b want 10", {rsp_allow, rsp_timeout}); end
    rsp_ready = 2'b01;
    step;
    rsp_ready = 2'b00;
    vectors++; if ({rsp_valid, rsp_allow} !== 3'b000) begin miscompares++; $display("FAIL single_release: got %b want 000", {rsp_valid, rsp_allow}); end
  endtask

  task automatic test_round_robin;
    logic [1:0]  exp;
    logic [63:0] ea;
    int unsigned w;
    do_reset;
    req_valid = 2'b11;
    chk_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      w   = k % 2;
      exp = (w == 1) ? 2'b10 : 2'b01;
      ea  = (w == 1) ? A1 : A0;
      #1;
      vectors++; if (req_ready !== exp) begin miscompares++; $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, exp); end
      step;
      vectors++; if (chk_addr !== ea || chk_sid !== 1'(w) || chk_nb !== ((w == 1) ? 4'd4 : 4'd8)) begin miscompares++; $display("FAIL rr_ops[%0d]: addr=%h sid=%b nb=%0d want addr=%h sid=%0d", k, chk_addr, chk_sid, chk_nb, ea, w); end
      step;
      chk_valid = 1'b1;
      chk_allow = (w == 1);
      step;
      chk_valid = 1'b0;
      vectors++; if (rsp_valid !== exp || rsp_allow !== (w == 1)) begin miscompares++; $display("FAIL rr_rsp[%0d]: valid=%b allow=%b want valid=%b allow=%0d", k, rsp_valid, rsp_allow, exp, w); end
      rsp_ready = 2'b11;
      step;
      rsp_ready = 2'b00;
    end
    req_valid = 2'b00;
  endtask

  task automatic test_chk_backpressure;
    req_valid = 2'b01;
    chk_ready = 1'b0;
    #1;
    step;
    req_valid = 2'b00;
    for (int i = 0; i < 6; i++) begin
      #1;
      vectors++; if (chk_en !== 1'b1 || chk_addr !== A0) begin miscompares++; $display("FAIL bp_issue[%0d]: en=%b addr=%h want en=1 addr=%h", i, chk_en, chk_addr, A0); end
      chk_valid = (i == 2);
      chk_allow = (i == 2);
      if (i == 5) chk_ready = 1'b1;
      step;
    end
    chk_valid = 1'b0;
    chk_allow = 1'b0;
    vectors++; if (chk_en !== 1'b0 || rsp_valid !== 2'b00 || chk_addr !== A0) begin miscompares++; $display("FAIL bp_wait: en=%b rsp_valid=%b addr=%h want 0 00 %h", chk_en, rsp_valid, chk_addr, A0); end
    chk_valid = 1'b1;
    step;
    chk_valid = 1'b0;
    vectors++; if ({rsp_valid, rsp_allow, rsp_timeout} !== 4'b0100) begin miscompares++; $display("FAIL bp_rsp: got %b want 0100", {rsp_valid, rsp_allow, rsp_timeout}); end
    rsp_ready = 2'b01;
    step;
    rsp_ready = 2'b00;
  endtask

  task automatic test_timeout;
    do_reset;
    req_valid = 2'b10;
    chk_ready = 1'b1;
    #1;
    vectors++; if (req_ready !== 2'b10) begin miscompares++; $display("FAIL to_wrap_grant: got %b want 10", req_ready); end
    step;
    req_valid = 2'b00;
    step;
    for (int i = 0; i < 4; i++) begin
      vectors++; if (rsp_valid !== 2'b00 || chk_en !== 1'b0) begin miscompares++; $display("FAIL to_wait[%0d]: rsp_valid=%b en=%b want 00 0", i, rsp_valid, chk_en); end
      step;
    end
    vectors++; if ({rsp_valid, rsp_allow, rsp_timeout} !== 4'b1001) begin miscompares++; $display("FAIL to_rsp: got %b want 1001", {rsp_valid, rsp_allow, rsp_timeout}); end
    rsp_ready = 2'b10;
    step;
    rsp_ready = 2'b00;
    req_valid = 2'b01;
    #1;
    step;
    req_valid = 2'b00;
    step;
    step;
    step;
    step;
    chk_valid = 1'b1;
    chk_allow = 1'b1;
    step;
    chk_valid = 1'b0;
    chk_allow = 1'b0;
    vectors++; if ({rsp_valid, rsp_allow, rsp_timeout} !== 4'b0110) begin miscompares++; $display("FAIL to_verdict_wins: got %b want 0110", {rsp_valid, rsp_allow, rsp_timeout}); end
    rsp_ready = 2'b01;
    step;
    rsp_ready = 2'b00;
  endtask

  task automatic test_rsp_backpressure;
    req_valid = 2'b01;
    #1;
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL rbp_grant: got %b want 01", req_ready); end
    step;
    req_valid = 2'b10;
    step;
    chk_valid = 1'b1;
    chk_allow = 1'b1;
    step;
    chk_valid = 1'b0;
    chk_allow = 1'b0;
    rsp_ready = 2'b10;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if ({rsp_valid, rsp_allow, rsp_timeout, req_ready} !== 6'b011000) begin miscompares++; $display("FAIL rbp_hold[%0d]: got %b want 011000", i, {rsp_valid, rsp_allow, rsp_timeout, req_ready}); end
      step;
    end
    vectors++; if (rsp_valid !== 2'b01) begin miscompares++; $display("FAIL rbp_still: got %b want 01", rsp_valid); end
    rsp_ready = 2'b01;
    step;
    rsp_ready = 2'b00;
    #1;
    vectors++; if (rsp_valid !== 2'b00 || req_ready !== 2'b10) begin miscompares++; $display("FAIL rbp_next: rsp_valid=%b req_ready=%b want 00 10", rsp_valid, req_ready); end
    step;
    req_valid = 2'b00;
    #1;
    vectors++; if (chk_addr !== A1 || chk_access !== 3'b010) begin miscompares++; $display("FAIL rbp_ops1: addr=%h acc=%b want %h 010", chk_addr, chk_access, A1); end
    step;
    chk_valid = 1'b1;
    step;
    chk_valid = 1'b0;
    vectors++; if ({rsp_valid, rsp_allow} !== 3'b100) begin miscompares++; $display("FAIL rbp_rsp1: got %b want 100", {rsp_valid, rsp_allow}); end
    rsp_ready = 2'b10;
    step;
    rsp_ready = 2'b00;
  endtask

  task automatic test_reset_mid_wait;
    req_valid = 2'b01;
    #1;
    step;
    req_valid = 2'b11;
    step;
    rst = 1'b1;
    chk_valid = 1'b1;
    chk_allow = 1'b1;
    step;
    chk_valid = 1'b0;
    chk_allow = 1'b0;
    vectors++; if ({req_ready, rsp_valid, chk_en, rsp_allow, rsp_timeout} !== 7'b0) begin miscompares++; $display("FAIL rmw_outputs: got %b want 0000000", {req_ready, rsp_valid, chk_en, rsp_allow, rsp_timeout}); end
    vectors++; if (chk_addr !== 64'h0) begin miscompares++; $display("FAIL rmw_addr: got %h want 0", chk_addr); end
    rst = 1'b0;
    #1;
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL rmw_regrant: got %b want 01", req_ready); end
    step;
    req_valid = 2'b00;
    #1;
    vectors++; if (chk_en !== 1'b1 || chk_addr !== A0 || rsp_valid !== 2'b00) begin miscompares++; $display("FAIL rmw_issue: en=%b addr=%h rsp=%b want 1 %h 00", chk_en, chk_addr, rsp_valid, A0); end
    step;
    step;
    vectors++; if (rsp_valid !== 2'b00) begin miscompares++; $display("FAIL rmw_discarded: got %b want 00", rsp_valid); end
    chk_valid = 1'b1;
    step;
    chk_valid = 1'b0;
    vectors++; if ({rsp_valid, rsp_allow, rsp_timeout} !== 4'b0100) begin miscompares++; $display("FAIL rmw_rsp: got %b want 0100", {rsp_valid, rsp_allow, rsp_timeout}); end
    rsp_ready = 2'b01;
    step;
    rsp_ready = 2'b00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    req_valid  = 2'b00;
    req_addr   = {A1, A0};
    req_nb     = {4'd4, 4'd8};
    req_sid    = 2'b10;
    req_access = {ACCESS_WRITE, ACCESS_READ};
    rsp_ready  = 2'b00;
    chk_ready  = 1'b0;
    chk_valid  = 1'b0;
    chk_allow  = 1'b0;
    test_reset;
    test_single;
    test_round_robin;
    test_chk_backpressure;
    test_timeout;
    test_rsp_backpressure;
    test_reset_mid_wait;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
